// File: rtl/mat_to_conv_accum_if.sv
// Beat-side and group-side signal bundle for mat_to_conv_accum.
// The master drives partial-product beats; the slave returns convolution output groups.
interface mat_to_conv_accum_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 8
);
    localparam int VW = NUM_LANES * DATA_WIDTH;

    logic          in_valid;
    logic          in_row_start;
    logic          in_abort;
    logic [VW-1:0] c_b_5;
    logic [VW-1:0] c_b_4;
    logic [VW-1:0] c_b_3;
    logic [VW-1:0] c_r_4;
    logic [VW-1:0] c_r_3;
    logic          out_valid;
    logic [VW-1:0] c1;
    logic [VW-1:0] c2;
    logic [VW-1:0] c3;
    logic          overflow;

    modport master (
        output in_valid, in_row_start, in_abort, c_b_5, c_b_4, c_b_3, c_r_4, c_r_3,
        input  out_valid, c1, c2, c3, overflow
    );

    modport slave (
        input  in_valid, in_row_start, in_abort, c_b_5, c_b_4, c_b_3, c_r_4, c_r_3,
        output out_valid, c1, c2, c3, overflow
    );
endinterface

// File: rtl/mat_to_conv_accum.sv
// Accumulates ACC_BEATS beats of five partial-product vectors per lane, then emits three
// convolution vectors with the r3/r4 sums shifted one lane up and carried across groups.
module mat_to_conv_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 8,
    parameter int ACC_BEATS  = 3,
    parameter bit SATURATE   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    mat_to_conv_accum_if.slave bus
);
    localparam int CW   = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;
    localparam int NV   = 5;
    localparam int V_B5 = 0;
    localparam int V_B4 = 1;
    localparam int V_B3 = 2;
    localparam int V_R4 = 3;
    localparam int V_R3 = 4;

    typedef struct packed {
        logic                  ovf;
        logic [DATA_WIDTH-1:0] val;
    } sum_t;

    typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] vec_t;

    // Signed add; overflow is flagged on the raw sum, clipping only when SATURATE is set.
    function automatic sum_t sadd(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] full;
        sum_t                res;
        full    = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        res.ovf = full[DATA_WIDTH] ^ full[DATA_WIDTH-1];
        res.val = full[DATA_WIDTH-1:0];
        if (SATURATE && res.ovf)
            res.val = full[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return res;
    endfunction

    logic [CW-1:0]                                 r_cnt;
    logic [NUM_LANES-1:0][NV-1:0][DATA_WIDTH-1:0]  r_acc;
    logic                                          r_row_start;
    logic [DATA_WIDTH-1:0]                         r_carry_r3;
    logic [DATA_WIDTH-1:0]                         r_carry_r4;
    vec_t                                          r_c1;
    vec_t                                          r_c2;
    vec_t                                          r_c3;
    logic                                          r_out_valid;
    logic                                          r_overflow;

    logic [NUM_LANES-1:0][NV-1:0][DATA_WIDTH-1:0]  w_in;
    logic [NUM_LANES-1:0][NV-1:0][DATA_WIDTH-1:0]  w_sum;
    vec_t                                          w_nb_r3;
    vec_t                                          w_nb_r4;
    vec_t                                          w_c2;
    vec_t                                          w_c3;
    logic [NUM_LANES-1:0]                          w_ovf_acc;
    logic [NUM_LANES-1:0]                          w_ovf_comb;
    logic                                          w_first;
    logic                                          w_last;
    logic                                          w_row_start;

    assign w_first     = (r_cnt == '0);
    assign w_last      = (r_cnt == CW'(ACC_BEATS - 1));
    // With a single-beat group the row-start flag is consumed in the same cycle it arrives.
    assign w_row_start = w_first ? bus.in_row_start : r_row_start;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sum_t [NV-1:0] w_add;
        logic [NV-1:0] w_add_ovf;
        sum_t          w_cmb2;
        sum_t          w_cmb3;

        assign w_in[i][V_B5] = bus.c_b_5[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_in[i][V_B4] = bus.c_b_4[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_in[i][V_B3] = bus.c_b_3[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_in[i][V_R4] = bus.c_r_4[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_in[i][V_R3] = bus.c_r_3[i*DATA_WIDTH +: DATA_WIDTH];

        for (genvar v = 0; v < NV; v++) begin : g_vec
            assign w_add[v]     = sadd(r_acc[i][v], w_in[i][v]);
            assign w_sum[i][v]  = w_first ? w_in[i][v] : w_add[v].val;
            assign w_add_ovf[v] = w_add[v].ovf;
        end

        if (i == 0) begin : g_carry_in
            assign w_nb_r3[i] = w_row_start ? '0 : r_carry_r3;
            assign w_nb_r4[i] = w_row_start ? '0 : r_carry_r4;
        end else begin : g_shift_in
            assign w_nb_r3[i] = w_sum[i-1][V_R3];
            assign w_nb_r4[i] = w_sum[i-1][V_R4];
        end

        assign w_cmb2        = sadd(w_sum[i][V_B4], w_nb_r3[i]);
        assign w_cmb3        = sadd(w_sum[i][V_B3], w_nb_r4[i]);
        assign w_c2[i]       = w_cmb2.val;
        assign w_c3[i]       = w_cmb3.val;
        assign w_ovf_acc[i]  = ~w_first & (|w_add_ovf);
        assign w_ovf_comb[i] = w_cmb2.ovf | w_cmb3.ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_row_start <= 1'b0;
            r_carry_r3  <= '0;
            r_carry_r4  <= '0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_c3        <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.in_abort) begin
                // The stale accumulators are simply overwritten by the next beat 0.
                r_cnt <= '0;
            end else if (bus.in_valid) begin
                r_acc <= w_sum;
                if (w_first)
                    r_row_start <= bus.in_row_start;
                if ((|w_ovf_acc) || (w_last && (|w_ovf_comb)))
                    r_overflow <= 1'b1;
                if (w_last) begin
                    r_cnt       <= '0;
                    r_out_valid <= 1'b1;
                    for (int i = 0; i < NUM_LANES; i++)
                        r_c1[i] <= w_sum[i][V_B5];
                    r_c2        <= w_c2;
                    r_c3        <= w_c3;
                    r_carry_r3  <= w_sum[NUM_LANES-1][V_R3];
                    r_carry_r4  <= w_sum[NUM_LANES-1][V_R4];
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.c1        = r_c1;
    assign bus.c2        = r_c2;
    assign bus.c3        = r_c3;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_mat_to_conv_accum.sv
// Five parameterisations share one stimulus stream; a plain-arithmetic model per instance
// pushes expected groups into queues and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mat_to_conv_accum;
    localparam int ND = 5;
    localparam int DW = 16;
    localparam int ML = 16;
    localparam int MW = ML * DW;

    typedef struct packed {
        logic [MW-1:0] c1;
        logic [MW-1:0] c2;
        logic [MW-1:0] c3;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_row_start = 1'b0;
    logic in_abort = 1'b0;
    logic [MW-1:0] v_b5 = '0, v_b4 = '0, v_b3 = '0, v_r4 = '0, v_r3 = '0;

    logic [ND-1:0]         mon_ov;
    logic [ND-1:0]         mon_ovf;
    logic [ND-1:0][MW-1:0] mon_c1;
    logic [ND-1:0][MW-1:0] mon_c2;
    logic [ND-1:0][MW-1:0] mon_c3;

    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    function automatic int cfg_nl(int d);  return (d == 3) ? 4 : (d == 4) ? 16 : 8; endfunction
    function automatic int cfg_ab(int d);  return (d == 2) ? 2 : (d == 3) ? 1 : (d == 4) ? 5 : 3; endfunction
    function automatic bit cfg_sat(int d); return (d == 1) || (d == 2); endfunction

    for (genvar d = 0; d < ND; d++) begin : g_dut
        localparam int NL  = (d == 3) ? 4 : (d == 4) ? 16 : 8;
        localparam int AB  = (d == 2) ? 2 : (d == 3) ? 1 : (d == 4) ? 5 : 3;
        localparam bit SAT = (d == 1) || (d == 2);

        mat_to_conv_accum_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

        assign bus.in_valid     = in_valid;
        assign bus.in_row_start = in_row_start;
        assign bus.in_abort     = in_abort;
        assign bus.c_b_5        = v_b5[NL*DW-1:0];
        assign bus.c_b_4        = v_b4[NL*DW-1:0];
        assign bus.c_b_3        = v_b3[NL*DW-1:0];
        assign bus.c_r_4        = v_r4[NL*DW-1:0];
        assign bus.c_r_3        = v_r3[NL*DW-1:0];
        assign mon_ov[d]        = bus.out_valid;
        assign mon_ovf[d]       = bus.overflow;
        assign mon_c1[d]        = MW'(bus.c1);
        assign mon_c2[d]        = MW'(bus.c2);
        assign mon_c3[d]        = MW'(bus.c3);

        mat_to_conv_accum #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_BEATS(AB), .SATURATE(SAT)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // ---------------- reference model ----------------
    int   m_cnt  [ND];
    int   m_acc  [ND][5][ML];
    bit   m_rs   [ND];
    int   m_car3 [ND];
    int   m_car4 [ND];
    bit   m_ovf  [ND];
    exp_t exp_q  [ND][$];

    function automatic bit ovf16(int a, int b);
        int s = a + b;
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic int add16(int a, int b, bit sat);
        int s = a + b;
        if (sat) begin
            if (s > 32767)  return 32767;
            if (s < -32768) return -32768;
            return s;
        end
        return ((s + 32768) & 65535) - 32768;
    endfunction

    function automatic int lane_of(logic [MW-1:0] v, int i);
        logic [DW-1:0] e;
        e = v[i*DW +: DW];
        return int'($signed(e));
    endfunction

    task automatic model_edge();
        int   in_v [5][ML];
        int   nl, ab, lo3, lo4;
        bit   sat;
        exp_t e;
        for (int i = 0; i < ML; i++) begin
            in_v[0][i] = lane_of(v_b5, i);
            in_v[1][i] = lane_of(v_b4, i);
            in_v[2][i] = lane_of(v_b3, i);
            in_v[3][i] = lane_of(v_r4, i);
            in_v[4][i] = lane_of(v_r3, i);
        end
        for (int d = 0; d < ND; d++) begin
            nl = cfg_nl(d); ab = cfg_ab(d); sat = cfg_sat(d);
            if (!rst_n) begin
                m_cnt[d] = 0; m_rs[d] = 0; m_car3[d] = 0; m_car4[d] = 0; m_ovf[d] = 0;
                continue;
            end
            if (in_abort) begin
                m_cnt[d] = 0;
                continue;
            end
            if (!in_valid) continue;
            for (int i = 0; i < nl; i++)
                for (int v = 0; v < 5; v++) begin
                    if (m_cnt[d] == 0) m_acc[d][v][i] = in_v[v][i];
                    else begin
                        if (ovf16(m_acc[d][v][i], in_v[v][i])) m_ovf[d] = 1;
                        m_acc[d][v][i] = add16(m_acc[d][v][i], in_v[v][i], sat);
                    end
                end
            if (m_cnt[d] == 0) m_rs[d] = in_row_start;
            if (m_cnt[d] == ab - 1) begin
                e = '0;
                for (int i = 0; i < nl; i++) begin
                    lo3 = (i == 0) ? (m_rs[d] ? 0 : m_car3[d]) : m_acc[d][4][i-1];
                    lo4 = (i == 0) ? (m_rs[d] ? 0 : m_car4[d]) : m_acc[d][3][i-1];
                    if (ovf16(m_acc[d][1][i], lo3) || ovf16(m_acc[d][2][i], lo4)) m_ovf[d] = 1;
                    e.c1[i*DW +: DW] = DW'(m_acc[d][0][i]);
                    e.c2[i*DW +: DW] = DW'(add16(m_acc[d][1][i], lo3, sat));
                    e.c3[i*DW +: DW] = DW'(add16(m_acc[d][2][i], lo4, sat));
                end
                m_car3[d] = m_acc[d][4][nl-1];
                m_car4[d] = m_acc[d][3][nl-1];
                e.ovf = m_ovf[d];
                exp_q[d].push_back(e);
                m_cnt[d] = 0;
            end else begin
                m_cnt[d]++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // ---------------- checking ----------------
    task automatic chk_vec(string nm, int d, logic [MW-1:0] act, logic [MW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    endtask

    task automatic chk_int(string nm, int d, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (mon_ov[d] === 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    chk_int("unexpected out_valid", d, 1, 0);
                end else begin
                    e = exp_q[d].pop_front();
                    chk_vec("c1", d, mon_c1[d], e.c1);
                    chk_vec("c2", d, mon_c2[d], e.c2);
                    chk_vec("c3", d, mon_c3[d], e.c3);
                    chk_int("overflow", d, int'(mon_ovf[d]), int'(e.ovf));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_const(int b5, int b4, int b3, int r3, int r4);
        for (int i = 0; i < ML; i++) begin
            v_b5[i*DW +: DW] = DW'(b5);
            v_b4[i*DW +: DW] = DW'(b4);
            v_b3[i*DW +: DW] = DW'(b3);
            v_r3[i*DW +: DW] = DW'(r3);
            v_r4[i*DW +: DW] = DW'(r4);
        end
    endtask

    function automatic logic [DW-1:0] rnd_elem();
        if ($urandom_range(0, 3) == 0) return DW'($urandom);
        return DW'(int'($urandom_range(0, 200)) - 100);
    endfunction

    task automatic set_rand();
        for (int i = 0; i < ML; i++) begin
            v_b5[i*DW +: DW] = rnd_elem();
            v_b4[i*DW +: DW] = rnd_elem();
            v_b3[i*DW +: DW] = rnd_elem();
            v_r3[i*DW +: DW] = rnd_elem();
            v_r4[i*DW +: DW] = rnd_elem();
        end
    endtask

    task automatic beat(bit vld, bit rs, bit ab);
        in_valid = vld; in_row_start = rs; in_abort = ab;
        @(posedge clk); #1;
        in_valid = 0; in_row_start = 0; in_abort = 0;
    endtask

    task automatic reset_pulse();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic chk_zero_state(string nm);
        for (int d = 0; d < ND; d++) begin
            chk_vec({nm, " outputs"}, d, mon_c1[d] | mon_c2[d] | mon_c3[d], '0);
            chk_int({nm, " valid/ovf"}, d, int'({mon_ov[d], mon_ovf[d]}), 0);
        end
    endtask

    task automatic chk_lane0(string nm, int c2e, int c3e);
        chk_int({nm, " c2 lane0"}, 0, lane_of(mon_c2[0], 0), c2e);
        chk_int({nm, " c3 lane0"}, 0, lane_of(mon_c3[0], 0), c3e);
    endtask

    initial begin
        bit vld, ab;
        set_const(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_state("reset");
        @(posedge clk); #1;
        rst_n = 1;

        // basic group with row start
        set_const(1, 2, 3, 10, 20);
        beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk_int("basic out_valid", 0, int'(mon_ov[0]), 1);
        chk_int("basic c1 lane5", 0, lane_of(mon_c1[0], 5), 3);
        chk_lane0("basic", 6, 9);
        chk_int("basic c2 lane1", 0, lane_of(mon_c2[0], 1), 36);
        chk_int("basic c3 lane7", 0, lane_of(mon_c3[0], 7), 69);

        // carry chain, then row start clears it again
        beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk_lane0("carry", 36, 69);
        beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk_lane0("row restart", 6, 9);

        // valid gaps 1,0,0,1,0,1
        beat(1, 1, 0); beat(0, 0, 0); beat(0, 0, 0); beat(1, 0, 0); beat(0, 0, 0); beat(1, 0, 0);
        chk_lane0("gaps", 6, 9);
        chk_int("gaps c2 lane3", 0, lane_of(mon_c2[0], 3), 36);

        // abort at count 0, then abort of a partial group (abort with valid high)
        beat(0, 0, 1);
        set_rand();
        beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 1);
        set_const(1, 2, 3, 10, 20);
        beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk_lane0("after abort", 36, 69);

        // reset mid-group
        beat(1, 0, 0);
        reset_pulse();
        chk_zero_state("mid reset");
        beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk_lane0("post reset", 6, 9);

        // saturating negative on two beats
        reset_pulse();
        set_const(-32768, 0, 0, 0, 0);
        beat(1, 1, 0); beat(1, 0, 0);
        chk_int("neg sat c1", 2, lane_of(mon_c1[2], 0), -32768);
        chk_int("neg sat ovf", 2, int'(mon_ovf[2]), 1);
        beat(1, 0, 0);

        // positive overflow, wrap vs saturate
        reset_pulse();
        set_const(32767, 0, 0, 0, 0);
        beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk_int("wrap c1", 0, lane_of(mon_c1[0], 0), 32765);
        chk_int("wrap ovf", 0, int'(mon_ovf[0]), 1);
        chk_int("sat c1", 1, lane_of(mon_c1[1], 0), 32767);

        // randomized traffic across all parameterisations
        reset_pulse();
        for (int n = 0; n < 7000; n++) begin
            set_rand();
            vld = ($urandom_range(0, 99) < 85);
            ab  = ($urandom_range(0, 99) < 2);
            beat(vld, 1'($urandom_range(0, 1)), ab);
        end
        repeat (4) beat(0, 0, 0);

        for (int d = 0; d < ND; d++)
            chk_int("pending groups", d, exp_q[d].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
